// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader.
// Loader FSM encodings, default UART timing and ROM geometry.
package program_loader_pkg;

  localparam int DEFAULT_CLK_PER_BIT = 868;
  localparam int DEFAULT_ROM_ADDRESS_BITWIDTH = 10;

  typedef enum logic [2:0] {
    LOADER_STATE_HEADER = 3'd0,
    LOADER_STATE_BODY   = 3'd1,
    LOADER_STATE_CHECK  = 3'd2,
    LOADER_STATE_DONE   = 3'd3,
    LOADER_STATE_ERROR  = 3'd4
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Replace byte lane k of a little-endian word.
  function automatic logic [31:0] place_byte(
    input logic [31:0] w,
    input logic [1:0]  k,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = w;
    unique case (k)
      2'd0: r[7:0]   = b;
      2'd1: r[15:8]  = b;
      2'd2: r[23:16] = b;
      2'd3: r[31:24] = b;
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/program_loader_uart_receiver.sv
// 8N1 UART receiver for the program loader.
// Synchronizes rx, times bits from a mid-start resample, shifts LSB first.
module uart_receiver
  import program_loader_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_error
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLK_PER_BIT - 1);

  logic          meta_q;
  logic          sync_q;
  logic          prev_q;
  rx_state_t     state_q;
  rx_state_t     state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [2:0]    bit_q;
  logic [2:0]    bit_d;
  logic [7:0]    shift_q;
  logic [7:0]    shift_d;
  logic          valid_q;
  logic          valid_d;
  logic          ferr_q;
  logic          ferr_d;

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // Receiver state, bit timer and shift register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state: start edge, mid-start glitch check, data and stop sampling.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = sync_q;
          ferr_d  = !sync_q;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid  = valid_q;
  assign byte_data   = shift_q;
  assign frame_error = ferr_q;

endmodule

// File: rtl/program_loader.sv
// Boot loader: UART image -> instruction ROM, holds core reset until done.
// Optional checksum word after the body: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int CLK_PER_BIT          = DEFAULT_CLK_PER_BIT,
  parameter int ROM_ADDRESS_BITWIDTH = DEFAULT_ROM_ADDRESS_BITWIDTH
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            uart_rx,
  output logic                            rom_wren,
  output logic [ROM_ADDRESS_BITWIDTH-1:0] rom_write_address,
  output logic [31:0]                     rom_write_data,
  output logic                            cpu_reset_n,
  output logic                            load_done,
  output logic                            load_error
);

  localparam int WAW = ROM_ADDRESS_BITWIDTH - 2;
  localparam logic [31:0] CAPACITY = 32'(1) << WAW;
  localparam logic [WAW:0] ONE = (WAW + 1)'(1);

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          frame_error;

  loader_state_t state_q;
  loader_state_t state_d;
  logic [1:0]    byte_cnt_q;
  logic [31:0]   word_buf_q;
  logic [WAW:0]  word_cnt_q;
  logic [WAW:0]  word_cnt_d;
  logic [WAW:0]  word_total_q;
  logic [WAW:0]  word_total_d;
  logic [31:0]   full_word;
  logic          accepting;
  logic          word_done;
  logic          strobe;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [31:0]   acc_q;
  logic [31:0]   acc_d;
`endif

  uart_receiver #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (uart_rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_error(frame_error)
  );

  // Word completes on the fourth byte; only loading states consume bytes.
  always_comb begin
    full_word = place_byte(word_buf_q, 2'd3, byte_data);
    accepting = (state_q == LOADER_STATE_HEADER) ||
                (state_q == LOADER_STATE_BODY) ||
                (state_q == LOADER_STATE_CHECK);
    word_done = accepting && byte_valid && (byte_cnt_q == 2'd3);
  end

  // Loader FSM next-state and write strobe decision.
  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    word_total_d = word_total_q;
    strobe       = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    acc_d        = acc_q;
`endif
    unique case (state_q)
      LOADER_STATE_HEADER: begin
        if (frame_error) begin
          state_d = LOADER_STATE_ERROR;
        end else if (word_done) begin
          word_cnt_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          acc_d = '0;
`endif
          if (full_word > CAPACITY) begin
            state_d = LOADER_STATE_ERROR;
          end else if (full_word == 32'd0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_d = LOADER_STATE_CHECK;
`else
            state_d = LOADER_STATE_DONE;
`endif
          end else begin
            word_total_d = full_word[WAW:0];
            state_d      = LOADER_STATE_BODY;
          end
        end
      end
      LOADER_STATE_BODY: begin
        if (frame_error) begin
          state_d = LOADER_STATE_ERROR;
        end else if (word_done) begin
          strobe     = 1'b1;
          word_cnt_d = word_cnt_q + ONE;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          acc_d = acc_q + full_word;
          if (word_cnt_q == word_total_q - ONE)
            state_d = LOADER_STATE_CHECK;
`else
          if (word_cnt_q == word_total_q - ONE)
            state_d = LOADER_STATE_DONE;
`endif
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      LOADER_STATE_CHECK: begin
        if (frame_error) begin
          state_d = LOADER_STATE_ERROR;
        end else if (word_done) begin
          state_d = (full_word == acc_q) ? LOADER_STATE_DONE
                                         : LOADER_STATE_ERROR;
        end
      end
`endif
      LOADER_STATE_DONE:  state_d = LOADER_STATE_DONE;
      LOADER_STATE_ERROR: state_d = LOADER_STATE_ERROR;
      default:            state_d = LOADER_STATE_ERROR;
    endcase
  end

  // FSM state, counters and byte assembly buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= LOADER_STATE_HEADER;
      byte_cnt_q   <= '0;
      word_buf_q   <= '0;
      word_cnt_q   <= '0;
      word_total_q <= '0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      word_total_q <= word_total_d;
      if (accepting && byte_valid) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
        word_buf_q <= place_byte(word_buf_q, byte_cnt_q, byte_data);
      end
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  // Running sum of body words.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) acc_q <= '0;
    else          acc_q <= acc_d;
  end
`endif

  // Registered ROM write port and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_wren          <= 1'b0;
      rom_write_address <= '0;
      rom_write_data    <= '0;
      cpu_reset_n       <= 1'b0;
      load_done         <= 1'b0;
      load_error        <= 1'b0;
    end else begin
      rom_wren <= strobe;
      if (strobe) begin
        rom_write_address <= {word_cnt_q[WAW-1:0], 2'b00};
        rom_write_data    <= full_word;
      end
      cpu_reset_n <= (state_q == LOADER_STATE_DONE);
      load_done   <= (state_q == LOADER_STATE_DONE);
      load_error  <= (state_q == LOADER_STATE_ERROR);
    end
  end

endmodule
